// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
// Opcode constants, fetch FSM encoding and instruction width.
package riscv_pkg;

    localparam int INSTR_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_pc_next.sv
// Next-PC adder for the fetch stage.
// Selects branch target or fall-through and flags misalignment.
module ifetch_pc_next #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr_pc,
    input  logic [XLEN-1:0] i_imm_ext,
    input  logic            i_pc_src,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misalign
);

    logic [XLEN-1:0] w_offset;

    assign w_offset   = i_pc_src ? i_imm_ext : XLEN'(4);
    assign o_next_pc  = i_instr_pc + w_offset;
    assign o_misalign = |o_next_pc[1:0];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request
// at a time and holds the fetched word until the core retires it.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               pc_src,
    input  logic [XLEN-1:0]    imm_ext,
    output logic               fetch_misalign,
    output logic [31:0]        instr_count
);

    ifetch_state_e      r_state;
    ifetch_state_e      w_state_next;
    logic [XLEN-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [XLEN-1:0]    r_instr_pc;
    logic               r_instr_valid;
    logic               r_fetch_misalign;
    logic [31:0]        r_instr_count;
    logic               w_req_valid;
    logic               w_capture;
    logic               w_retire;
    logic [XLEN-1:0]    w_next_pc;
    logic               w_misalign;

    ifetch_pc_next #(
        .XLEN(XLEN)
    ) u_pc_next (
        .i_instr_pc (r_instr_pc),
        .i_imm_ext  (imm_ext),
        .i_pc_src   (pc_src),
        .o_next_pc  (w_next_pc),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        unique case (r_state)
            S_REQ: begin
                w_req_valid = 1'b1;
                if (imem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    w_retire     = 1'b1;
                    w_state_next = w_misalign ? S_HALT : S_REQ;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_instr          <= '0;
            r_instr_pc       <= '0;
            r_instr_valid    <= 1'b0;
            r_fetch_misalign <= 1'b0;
            r_instr_count    <= '0;
        end else begin
            if (w_capture) begin
                r_instr       <= imem_rsp_data;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end
            if (w_retire) begin
                r_instr_valid <= 1'b0;
                r_instr_count <= r_instr_count + 32'd1;
                if (w_misalign) begin
                    r_fetch_misalign <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    // Request is masked during the reset cycle itself.
    assign imem_req_valid = w_req_valid & rst_n;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign fetch_misalign = r_fetch_misalign;
    assign instr_count    = r_instr_count;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed and randomized checks of ifetch_unit against
// a PC/count reference model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] imm_ext = '0;
    logic        fetch_misalign;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    ifetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .pc_src         (pc_src),
        .imm_ext        (imm_ext),
        .fetch_misalign (fetch_misalign),
        .instr_count    (instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready = 1'b0;
        tick();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
        check("rst_count", instr_count, 32'd0);
        m_pc = 32'h0;
        m_cnt = 32'd0;
        m_mis = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic fetch(input int stall, input int lat,
                         input logic [31:0] data, input bit spur);
        for (int i = 0; i < stall; i++) begin
            check("req_valid_stall", 32'(imem_req_valid), 32'd1);
            check("req_addr_stall", imem_req_addr, m_pc);
            imem_rsp_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rsp_data = $urandom;
            tick();
        end
        imem_rsp_valid = 1'b0;
        check("req_valid", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_req_addr, m_pc);
        check("no_instr_in_req", 32'(instr_valid), 32'd0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("req_valid_wait", 32'(imem_req_valid), 32'd0);
            tick();
        end
        check("req_valid_wait", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
        m_instr = data;
        m_ipc = m_pc;
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
    endtask

    task automatic retire(input int hold, input logic src,
                          input logic [31:0] imm);
        logic [31:0] nxt;
        for (int i = 0; i < hold; i++) begin
            pc_src = 1'($urandom_range(0, 1));
            imm_ext = $urandom;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data = $urandom;
            tick();
            check("hold_instr", instr, m_instr);
            check("hold_pc", instr_pc, m_ipc);
            check("hold_valid", 32'(instr_valid), 32'd1);
        end
        imem_rsp_valid = 1'b0;
        instr_ready = 1'b1;
        pc_src = src;
        imm_ext = imm;
        tick();
        instr_ready = 1'b0;
        pc_src = 1'($urandom_range(0, 1));
        imm_ext = $urandom;
        nxt = src ? m_ipc + imm : m_ipc + 32'd4;
        m_cnt = m_cnt + 32'd1;
        if (nxt % 4 != 0) m_mis = 1'b1;
        else m_pc = nxt;
        check("ret_instr_valid", 32'(instr_valid), 32'd0);
        check("ret_count", instr_count, m_cnt);
        check("ret_misalign", 32'(fetch_misalign), 32'(m_mis));
        check("ret_req_valid", 32'(imem_req_valid), 32'(!m_mis));
        if (!m_mis) check("ret_req_addr", imem_req_addr, m_pc);
    endtask

    initial begin
        m_pc = '0;
        m_cnt = '0;
        m_mis = 1'b0;
        m_instr = '0;
        m_ipc = '0;

        do_reset();
        fetch(0, 0, 32'h00500093, 1'b0);
        check("t1_instr", instr, 32'h00500093);
        check("t1_pc", instr_pc, 32'h0);

        retire(0, 1'b0, 32'h0);
        fetch(0, 0, 32'h00100113, 1'b0);
        retire(1, 1'b0, 32'h0);
        fetch(0, 1, 32'h002081b3, 1'b0);
        retire(0, 1'b0, 32'h0);
        fetch(0, 0, 32'h0041a023, 1'b0);
        retire(0, 1'b0, 32'h0);
        check("t2_count", instr_count, 32'd4);
        check("t2_addr", imem_req_addr, 32'h10);

        fetch(0, 0, 32'hfe000ce3, 1'b0);
        retire(0, 1'b1, 32'hFFFF_FFF8);
        check("t3_back", imem_req_addr, 32'h08);
        fetch(0, 0, 32'h00000013, 1'b0);
        retire(0, 1'b0, 32'h0);
        fetch(0, 0, 32'h00000013, 1'b0);
        retire(0, 1'b0, 32'h0);
        fetch(0, 0, 32'h02000063, 1'b0);
        retire(0, 1'b1, 32'h20);
        check("t3_fwd", imem_req_addr, 32'h30);

        fetch(5, 0, 32'h00c00293, 1'b1);
        retire(0, 1'b0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            logic        src;
            logic [31:0] imm;
            src = 1'($urandom_range(0, 1));
            imm = 32'(($urandom_range(0, 64) - 32) * 4);
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
            retire($urandom_range(0, 2), src, imm);
        end

        fetch(0, 0, 32'h00000013, 1'b0);
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        m_cnt = 32'hFFFF_FFFF;
        retire(0, 1'b0, 32'h0);
        check("wrap_count", instr_count, 32'd0);

        do_reset();
        fetch(0, 0, 32'h00600063, 1'b0);
        retire(0, 1'b1, 32'h6);
        check("t5_misalign", 32'(fetch_misalign), 32'd1);
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            instr_ready = 1'b1;
            tick();
            check("halt_req_valid", 32'(imem_req_valid), 32'd0);
            check("halt_instr_valid", 32'(instr_valid), 32'd0);
            check("halt_misalign", 32'(fetch_misalign), 32'd1);
        end
        imem_rsp_valid = 1'b0;

        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("t6_wait", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        check("t6_rst_req", 32'(imem_req_valid), 32'd0);
        check("t6_rst_iv", 32'(instr_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("t6_late_iv", 32'(instr_valid), 32'd0);
        check("t6_late_req", 32'(imem_req_valid), 32'd1);
        check("t6_late_addr", imem_req_addr, 32'h0);
        imem_rsp_valid = 1'b0;
        m_pc = 32'h0;
        m_cnt = 32'd0;
        m_mis = 1'b0;
        fetch(0, 2, 32'h00500093, 1'b0);
        retire(0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
